// File: rtl/alu_seq.sv
// Sequential RV-style integer ALU: single-cycle arithmetic/logic ops, multi-cycle
// shifts of up to SHIFT_STEP bits per cycle, valid/ready on both request and result.
module alu_seq #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o,
  output logic            err_o
);

  localparam int unsigned SW = $clog2(XLEN);
  // One extra bit so a step equal to XLEN is representable.
  localparam logic [SW:0] STEP_W = (SW+1)'(SHIFT_STEP);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1101;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state;
  logic [3:0]      op_q;
  logic [SW-1:0]   rem;

  logic [XLEN-1:0] alu_res;
  logic            alu_err;
  logic            is_shift;
  logic [SW-1:0]   amt;
  logic [SW:0]     step_ext;
  logic [SW-1:0]   step;
  logic [SW-1:0]   rem_next;
  logic [XLEN-1:0] shifted;

  assign amt = b_i[SW-1:0];

  always_comb begin
    alu_res  = '0;
    alu_err  = 1'b0;
    is_shift = 1'b0;
    case (op_i)
      OP_ADD:  alu_res = a_i + b_i;
      OP_SUB:  alu_res = a_i - b_i;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (a_i < b_i)};
      OP_XOR:  alu_res = a_i ^ b_i;
      OP_OR:   alu_res = a_i | b_i;
      OP_AND:  alu_res = a_i & b_i;
      OP_SLL, OP_SRL, OP_SRA: begin
        is_shift = 1'b1;
        alu_res  = a_i;
      end
      default: alu_err = 1'b1;
    endcase
  end

  // Per-cycle shift distance is min(SHIFT_STEP, remaining); it never exceeds rem.
  always_comb begin
    step_ext = ({1'b0, rem} > STEP_W) ? STEP_W : {1'b0, rem};
    step     = step_ext[SW-1:0];
    rem_next = rem - step;
    case (op_q)
      OP_SLL:  shifted = result_o << step;
      OP_SRA:  shifted = $signed(result_o) >>> step;
      default: shifted = result_o >> step;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ready_o  <= 1'b1;
      valid_o  <= 1'b0;
      result_o <= '0;
      zero_o   <= 1'b0;
      err_o    <= 1'b0;
      rem      <= '0;
      op_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i && ready_o) begin
            op_q     <= op_i;
            ready_o  <= 1'b0;
            result_o <= alu_res;
            zero_o   <= (alu_res == '0);
            err_o    <= alu_err;
            if (is_shift && (amt != '0)) begin
              rem   <= amt;
              state <= SHIFT;
            end else begin
              valid_o <= 1'b1;
              state   <= DONE;
            end
          end
        end
        SHIFT: begin
          result_o <= shifted;
          zero_o   <= (shifted == '0);
          rem      <= rem_next;
          if (rem_next == '0) begin
            valid_o <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            ready_o <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          valid_o <= 1'b0;
          ready_o <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: two instances (SHIFT_STEP=1 and 4), scoreboard of
// expected result/flags/latency, immediate assertions at each check.
module tb_alu_seq;

  localparam int XLEN = 32;

  typedef struct {
    logic [XLEN-1:0] res;
    logic            zero;
    logic            err;
    int              lat;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic            valid_in  [2];
  logic            ready_out [2];
  logic [3:0]      op_in     [2];
  logic [XLEN-1:0] a_in      [2];
  logic [XLEN-1:0] b_in      [2];
  logic            valid_out [2];
  logic            ready_in  [2];
  logic [XLEN-1:0] res_out   [2];
  logic            zero_out  [2];
  logic            err_out   [2];

  int   total;
  int   bad;
  exp_t sb[$];

  alu_seq #(.XLEN(XLEN), .SHIFT_STEP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_in[0]), .ready_o(ready_out[0]),
    .op_i(op_in[0]), .a_i(a_in[0]), .b_i(b_in[0]), .valid_o(valid_out[0]),
    .ready_i(ready_in[0]), .result_o(res_out[0]), .zero_o(zero_out[0]), .err_o(err_out[0])
  );

  alu_seq #(.XLEN(XLEN), .SHIFT_STEP(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_in[1]), .ready_o(ready_out[1]),
    .op_i(op_in[1]), .a_i(a_in[1]), .b_i(b_in[1]), .valid_o(valid_out[1]),
    .ready_i(ready_in[1]), .result_o(res_out[1]), .zero_o(zero_out[1]), .err_o(err_out[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one request; leaves the DUT in DONE (when hold=1) or releases it.
  task automatic run(input int s, input logic [3:0] op, input logic [XLEN-1:0] a,
                     input logic [XLEN-1:0] b, input logic [XLEN-1:0] r,
                     input logic e, input int lat, input bit hold);
    exp_t x;
    exp_t got;
    int   n;
    x.res = r; x.zero = (r == '0); x.err = e; x.lat = lat;
    sb.push_back(x);
    @(negedge clk);
    chk("ready_before_req", ready_out[s], 1'b1);
    valid_in[s] = 1'b1; op_in[s] = op; a_in[s] = a; b_in[s] = b;
    @(posedge clk);
    @(negedge clk);
    valid_in[s] = 1'b0; op_in[s] = 4'hf; a_in[s] = '1; b_in[s] = '1;
    n = 1;
    while (!valid_out[s] && n < 100) begin
      @(negedge clk);
      n++;
    end
    got = sb.pop_front();
    chk($sformatf("op%h_latency", op), 64'(n), 64'(got.lat));
    chk($sformatf("op%h_result", op), 64'(res_out[s]), 64'(got.res));
    chk($sformatf("op%h_zero", op), 64'(zero_out[s]), 64'(got.zero));
    chk($sformatf("op%h_err", op), 64'(err_out[s]), 64'(got.err));
    if (!hold) begin
      ready_in[s] = 1'b1;
      @(negedge clk);
      ready_in[s] = 1'b0;
      chk("valid_drop", valid_out[s], 1'b0);
      chk("ready_back", ready_out[s], 1'b1);
    end
  endtask

  initial begin
    logic [XLEN-1:0] held;
    int              seen;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      valid_in[i] = 1'b0; ready_in[i] = 1'b0; op_in[i] = '0; a_in[i] = '0; b_in[i] = '0;
    end
    // Reset state, with valid_i asserted to show it is ignored.
    #2 valid_in[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", valid_out[0], 1'b0);
    chk("rst_ready", ready_out[0], 1'b1);
    chk("rst_result", res_out[0], '0);
    chk("rst_zero", zero_out[0], 1'b0);
    chk("rst_err", err_out[0], 1'b0);
    valid_in[0] = 1'b0;
    rst_n = 1'b1;

    // Arithmetic / logic, latency 1.
    run(0, 4'b0000, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1, 1'b0);
    run(0, 4'b1000, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1, 1'b0);
    run(0, 4'b0010, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1, 1'b0);
    run(0, 4'b0011, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1, 1'b0);
    run(0, 4'b0100, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 1'b0, 1, 1'b0);
    run(0, 4'b0110, 32'h0000_00A0, 32'h0000_050A, 32'h0000_05AA, 1'b0, 1, 1'b0);
    run(0, 4'b0111, 32'hDEAD_BEEF, 32'h0000_FFFF, 32'h0000_BEEF, 1'b0, 1, 1'b0);
    // Illegal opcode.
    run(0, 4'b1010, 32'h1234, 32'h1, 32'h0, 1'b1, 1, 1'b0);
    // Shifts, step 1.
    run(0, 4'b1101, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 32, 1'b0);
    run(0, 4'b0001, 32'h3, 32'hFFFF_FFE3, 32'h18, 1'b0, 4, 1'b0);
    run(0, 4'b0001, 32'hABCD, 32'h20, 32'hABCD, 1'b0, 1, 1'b0);
    // Shifts, step 4.
    run(1, 4'b0001, 32'h1, 32'h25, 32'h20, 1'b0, 3, 1'b0);
    run(1, 4'b0101, 32'hF000_0000, 32'd7, 32'h01E0_0000, 1'b0, 3, 1'b0);
    run(1, 4'b1101, 32'h8000_0010, 32'd3, 32'hF000_0002, 1'b0, 2, 1'b0);
    run(1, 4'b0101, 32'h8000_0000, 32'd31, 32'h1, 1'b0, 9, 1'b0);

    // Hold in DONE for 5 cycles with valid_i pulses.
    run(0, 4'b0000, 32'd100, 32'd23, 32'd123, 1'b0, 1, 1'b1);
    held = res_out[0];
    for (int i = 0; i < 5; i++) begin
      valid_in[0] = i[0]; op_in[0] = 4'b0000; a_in[0] = 32'd1; b_in[0] = 32'd1;
      @(negedge clk);
      chk("hold_result", res_out[0], held);
      chk("hold_ready", ready_out[0], 1'b0);
      chk("hold_valid", valid_out[0], 1'b1);
    end
    valid_in[0] = 1'b0;
    ready_in[0] = 1'b1;
    @(negedge clk);
    ready_in[0] = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (valid_out[0] || !ready_out[0]) seen++;
      @(negedge clk);
    end
    chk("hold_no_extra_accept", 64'(seen), 64'd0);

    // Reset during SRL b=20, third SHIFT cycle.
    @(negedge clk);
    valid_in[0] = 1'b1; op_in[0] = 4'b0101; a_in[0] = 32'hFFFF_0000; b_in[0] = 32'd20;
    @(posedge clk);
    @(negedge clk);
    valid_in[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", ready_out[0], 1'b1);
    chk("abort_valid", valid_out[0], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (valid_out[0]) seen++;
    end
    chk("abort_no_result", 64'(seen), 64'd0);
    run(0, 4'b0000, 32'd2, 32'd3, 32'd5, 1'b0, 1, 1'b0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
